// File: rtl/music_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : music_sequencer_pkg
// Brief  : State encodings, ROM byte fields and duration decode for the
//          music sequencer.
// Rev    : 1.0
// ============================================================================
package music_sequencer_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_LATCH = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_PLAY  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd5;

    localparam int c_DUR_MSB   = 7;
    localparam int c_DUR_LSB   = 5;
    localparam int c_PITCH_MSB = 4;
    localparam int c_PITCH_LSB = 0;

    localparam logic [7:0] c_END_CODE = 8'h00;

    // A zero duration field encodes the longest note, eight units.
    function automatic logic [3:0] dur_units(input logic [2:0] field);
        return (field == 3'd0) ? 4'd8 : {1'b0, field};
    endfunction

endpackage
`default_nettype wire

// File: rtl/music_sequencer_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : edge_detect
// Brief  : Registers an asynchronous level and flags its rising edge for
//          one clock cycle.
// Rev    : 1.0
// ============================================================================
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic r_cur;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= din;
            r_prev <= r_cur;
        end
    end

    assign pulse = r_cur & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
// Module : music_sequencer
// Brief  : Steps through an external music ROM, holding each note for a
//          number of vsync frames given by its duration field.
// Rev    : 1.0
// ============================================================================
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int FRAME_MULT = 4,
    parameter int LOOP       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic              vsync,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [4:0]        note,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [4:0]           r_note;
    logic                 r_note_valid;
    logic [7:0]           r_frames;

    logic                 w_vs_edge;
    logic                 w_tick;
    logic                 w_last_frame;
    logic                 w_is_end;
    logic [4:0]           w_pitch;
    logic [7:0]           w_load;

    edge_detect u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (vsync),
        .pulse (w_vs_edge)
    );

    assign w_is_end     = (rom_data == c_END_CODE);
    assign w_pitch      = rom_data[c_PITCH_MSB:c_PITCH_LSB];
    assign w_load       = 8'(dur_units(rom_data[c_DUR_MSB:c_DUR_LSB])) * 8'(FRAME_MULT);
    // Frame edges only count while a note is playing and not paused.
    assign w_tick       = w_vs_edge && !pause && (r_state == c_ST_PLAY);
    assign w_last_frame = w_tick && (r_frames == 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (play) w_next = c_ST_FETCH;
                c_ST_FETCH: w_next = c_ST_WAIT;
                c_ST_WAIT:  w_next = c_ST_LATCH;
                c_ST_LATCH: begin
                    if (!w_is_end)     w_next = c_ST_PLAY;
                    else if (LOOP != 0) w_next = c_ST_FETCH;
                    else               w_next = c_ST_DONE;
                end
                c_ST_PLAY:  if (w_last_frame) w_next = c_ST_FETCH;
                c_ST_DONE:  w_next = c_ST_IDLE;
                default:    w_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != c_ST_IDLE);
        done = (r_state == c_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_addr       <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
            r_frames     <= '0;
        end else begin
            case (r_state)
                c_ST_LATCH: begin
                    if (w_is_end) begin
                        // Address returns to 0 for a loop restart and for a clean IDLE.
                        r_addr <= '0;
                        if (LOOP == 0) r_note_valid <= 1'b0;
                    end else begin
                        r_note       <= w_pitch;
                        r_note_valid <= (w_pitch != 5'd0);
                        r_frames     <= w_load;
                    end
                end
                c_ST_PLAY: begin
                    if (w_last_frame) begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_frames <= '0;
                    end else if (w_tick) begin
                        r_frames <= r_frames - 8'd1;
                    end
                end
                c_ST_DONE: r_note_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign note       = r_note;
    assign note_valid = r_note_valid;

endmodule
`default_nettype wire

// File: tb/tb_music_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_music_sequencer
// Brief  : Directed self-checking bench for music_sequencer (stop and loop
//          instances sharing one clock).
// Rev    : 1.0
// ============================================================================
module tb_music_sequencer;

    logic clk = 1'b0;
    logic reset, stop, pause, vsync, play0, play1;

    logic [7:0]  rom0 [0:2047];
    logic [7:0]  rom1 [0:7];
    logic [7:0]  rom_data0, rom_data1;
    logic [10:0] rom_addr0;
    logic [2:0]  rom_addr1;
    logic [4:0]  note0, note1;
    logic        nv0, nv1, busy0, busy1, done0, done1;
    logic        seen_done1 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    music_sequencer #(.ADDR_W(11), .FRAME_MULT(4), .LOOP(0)) dut0 (
        .clk(clk), .reset(reset), .play(play0), .stop(stop), .pause(pause),
        .vsync(vsync), .rom_data(rom_data0), .rom_addr(rom_addr0),
        .note(note0), .note_valid(nv0), .busy(busy0), .done(done0)
    );

    music_sequencer #(.ADDR_W(3), .FRAME_MULT(4), .LOOP(1)) dut1 (
        .clk(clk), .reset(reset), .play(play1), .stop(stop), .pause(pause),
        .vsync(vsync), .rom_data(rom_data1), .rom_addr(rom_addr1),
        .note(note1), .note_valid(nv1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        rom_data0 <= rom0[rom_addr0];
        rom_data1 <= rom1[rom_addr1];
        if (done1) seen_done1 <= 1'b1;
    end

    typedef struct {
        string      name;
        logic [7:0] b;
        logic [4:0] exp_note;
        logic       exp_nv;
        int         frames;
    } vec_t;

    vec_t vecs [5];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One vsync period; the edge is consumed by PLAY on the second clock.
    task automatic frame(input int n = 1);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            tick(2);
            vsync = 1'b0;
            tick(2);
        end
    endtask

    task automatic start0();
        play0 = 1'b1;
        tick();
        play0 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"dur2_p1",  8'h41, 5'd1,  1'b1, 8};
        vecs[1] = '{"dur0_p5",  8'h05, 5'd5,  1'b1, 32};
        vecs[2] = '{"rest",     8'h20, 5'd0,  1'b0, 4};
        vecs[3] = '{"dur7_p31", 8'hFF, 5'd31, 1'b1, 28};
        vecs[4] = '{"dur1_p31", 8'h3F, 5'd31, 1'b1, 4};

        for (int i = 0; i < 2048; i++) rom0[i] = 8'h00;
        for (int i = 0; i < 8; i++)    rom1[i] = 8'h00;
        reset = 1'b1; stop = 1'b0; pause = 1'b0; vsync = 1'b0;
        play0 = 1'b0; play1 = 1'b0;
        tick(3);

        check("rst_addr",  32'(rom_addr0), 0);
        check("rst_note",  32'(note0), 0);
        check("rst_nv",    32'(nv0), 0);
        check("rst_busy",  32'(busy0), 0);
        check("rst_done",  32'(done0), 0);
        check("rst_busy1", 32'(busy1), 0);
        reset = 1'b0;
        tick();

        // Single-note songs, each followed by the end marker.
        for (int v = 0; v < 5; v++) begin
            rom0[0] = vecs[v].b;
            rom0[1] = 8'h00;
            tick();
            start0();
            tick(2);
            check({vecs[v].name, "_lat3_nv"}, 32'(nv0), 0);
            check({vecs[v].name, "_busy"}, 32'(busy0), 1);
            tick();
            check({vecs[v].name, "_note"}, 32'(note0), 32'(vecs[v].exp_note));
            check({vecs[v].name, "_nv"}, 32'(nv0), 32'(vecs[v].exp_nv));
            frame(vecs[v].frames - 1);
            check({vecs[v].name, "_hold_addr"}, 32'(rom_addr0), 0);
            check({vecs[v].name, "_hold_note"}, 32'(note0), 32'(vecs[v].exp_note));
            frame();
            check({vecs[v].name, "_next_addr"}, 32'(rom_addr0), 1);
            check({vecs[v].name, "_no_done"}, 32'(done0), 0);
            tick();
            check({vecs[v].name, "_done"}, 32'(done0), 1);
            check({vecs[v].name, "_done_nv"}, 32'(nv0), 0);
            tick();
            check({vecs[v].name, "_done_off"}, 32'(done0), 0);
            check({vecs[v].name, "_idle"}, 32'(busy0), 0);
            check({vecs[v].name, "_idle_addr"}, 32'(rom_addr0), 0);
        end

        // Edges in IDLE are dropped; pause stretches the note by 10 frames.
        rom0[0] = 8'h21; rom0[1] = 8'h00;
        frame(3);
        start0();
        tick(3);
        frame(2);
        pause = 1'b1;
        frame(10);
        pause = 1'b0;
        check("pause_addr", 32'(rom_addr0), 0);
        check("pause_nv", 32'(nv0), 1);
        frame();
        check("pause_addr_m1", 32'(rom_addr0), 0);
        frame();
        check("pause_addr_end", 32'(rom_addr0), 1);
        tick(2);
        check("pause_idle", 32'(busy0), 0);

        // Play during playback is ignored; stop beats a simultaneous play.
        rom0[0] = 8'h21; rom0[1] = 8'h22; rom0[2] = 8'h00;
        start0();
        tick(3);
        frame(4);
        tick();
        check("seq2_note", 32'(note0), 2);
        check("seq2_addr", 32'(rom_addr0), 1);
        play0 = 1'b1;
        tick();
        play0 = 1'b0;
        check("busy_play_note", 32'(note0), 2);
        check("busy_play_addr", 32'(rom_addr0), 1);
        stop = 1'b1; play0 = 1'b1;
        tick();
        stop = 1'b0; play0 = 1'b0;
        check("stop_busy", 32'(busy0), 0);
        check("stop_addr", 32'(rom_addr0), 0);
        check("stop_nv", 32'(nv0), 0);
        check("stop_note", 32'(note0), 0);
        check("stop_done", 32'(done0), 0);
        tick();
        check("stop_stays_idle", 32'(busy0), 0);

        // Reset mid-note, then restart from address 0.
        start0();
        tick(3);
        frame(4);
        tick();
        check("prerst_addr", 32'(rom_addr0), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_addr", 32'(rom_addr0), 0);
        check("midrst_note", 32'(note0), 0);
        check("midrst_nv", 32'(nv0), 0);
        check("midrst_busy", 32'(busy0), 0);
        start0();
        tick(3);
        check("rerun_note", 32'(note0), 1);
        check("rerun_addr", 32'(rom_addr0), 0);

        // Loop instance: end marker restarts at 0 with no done pulse.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        rom1[0] = 8'h21; rom1[1] = 8'h00;
        tick();
        play1 = 1'b1;
        tick();
        play1 = 1'b0;
        tick(3);
        check("loop_note", 32'(note1), 1);
        frame(4);
        check("loop_addr1", 32'(rom_addr1), 1);
        tick();
        check("loop_addr0", 32'(rom_addr1), 0);
        check("loop_busy", 32'(busy1), 1);
        tick(3);
        check("loop_replay_note", 32'(note1), 1);
        check("loop_replay_nv", 32'(nv1), 1);
        check("loop_no_done", 32'(seen_done1), 0);

        // Address wrap 7 -> 0 with no end indication.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 8; i++) rom1[i] = 8'h21 + 8'(i);
        tick();
        play1 = 1'b1;
        tick();
        play1 = 1'b0;
        tick(3);
        for (int k = 0; k < 8; k++) begin
            check("wrap_note", 32'(note1), k + 1);
            frame(4);
            tick();
        end
        check("wrap_addr", 32'(rom_addr1), 0);
        check("wrap_note0", 32'(note1), 1);
        check("wrap_no_done", 32'(seen_done1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
